// File: rtl/lane_dispatch_sequencer.sv
// Lane dispatch sequencer: accepts an active-lane mask per warp batch and
// issues one lane ID per cycle in rotating order from a start position,
// then reports completion with the number of lanes issued.
module lane_dispatch_sequencer #(
   parameter int NUM_LANES = 8,
   parameter int LANE_W    = 3,
   parameter int WID_W     = 4,
   parameter int CNT_W     = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NUM_LANES-1:0] in_mask,
   input  logic [WID_W-1:0]     in_wid,
   input  logic [LANE_W-1:0]    in_start,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANE_W-1:0]    out_lane,
   output logic [WID_W-1:0]     out_wid,
   input  logic                 abort,
   output logic                 done,
   output logic [WID_W-1:0]     done_wid,
   output logic [CNT_W-1:0]     done_count
);

   // state | meaning
   // IDLE  | waiting for a batch, in_ready high unless aborting
   // SCAN  | issuing lanes from pending, one wrap bubble allowed
   // DONE  | one-cycle completion pulse, then back to IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_LANES-1:0] pending_q, pending_d;
   logic [LANE_W-1:0]    ptr_q, ptr_d;
   logic [WID_W-1:0]     wid_q, wid_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 done_q, done_d;
   logic [WID_W-1:0]     done_wid_q, done_wid_d;
   logic [CNT_W-1:0]     done_count_q, done_count_d;

   logic [NUM_LANES-1:0] window;
   logic [NUM_LANES-1:0] pending_after;
   logic                 hit;
   logic [LANE_W-1:0]    pos;
   logic                 xfer;

   // Non-wrapping search: lowest pending lane at or above ptr.
   always_comb begin
      window = pending_q & ({NUM_LANES{1'b1}} << ptr_q);
      hit    = |window;
      pos    = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--) begin
         if (window[i]) pos = LANE_W'(i);
      end
   end

   assign in_ready      = (state_q == ST_IDLE) && !abort;
   assign out_valid     = (state_q == ST_SCAN) && hit && !abort;
   assign out_lane      = pos;
   assign out_wid       = wid_q;
   assign xfer          = out_valid && out_ready;
   assign pending_after = pending_q & ~(NUM_LANES'(1) << pos);

   assign done       = done_q;
   assign done_wid   = done_wid_q;
   assign done_count = done_count_q;

   // Next-state logic; abort overrides everything and never raises done.
   always_comb begin
      state_d      = state_q;
      pending_d    = pending_q;
      ptr_d        = ptr_q;
      wid_d        = wid_q;
      count_d      = count_q;
      done_d       = 1'b0;
      done_wid_d   = done_wid_q;
      done_count_d = done_count_q;

      if (abort) begin
         state_d   = ST_IDLE;
         pending_d = '0;
         count_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  pending_d = in_mask;
                  wid_d     = in_wid;
                  ptr_d     = in_start;
                  count_d   = '0;
                  if (in_mask == '0) begin
                     state_d      = ST_DONE;
                     done_d       = 1'b1;
                     done_wid_d   = in_wid;
                     done_count_d = '0;
                  end else begin
                     state_d = ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (xfer) begin
                  pending_d = pending_after;
                  count_d   = count_q + CNT_W'(1);
                  // LANE_W-bit add wraps lane 7 straight to 0, no bubble
                  ptr_d     = pos + LANE_W'(1);
                  if (pending_after == '0) begin
                     state_d      = ST_DONE;
                     done_d       = 1'b1;
                     done_wid_d   = wid_q;
                     done_count_d = count_q + CNT_W'(1);
                  end
               end else if (!hit && (pending_q != '0)) begin
                  ptr_d = '0;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d   = ST_IDLE;
               pending_d = '0;
               count_d   = '0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         pending_q    <= '0;
         ptr_q        <= '0;
         wid_q        <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
         done_wid_q   <= '0;
         done_count_q <= '0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         ptr_q        <= ptr_d;
         wid_q        <= wid_d;
         count_q      <= count_d;
         done_q       <= done_d;
         done_wid_q   <= done_wid_d;
         done_count_q <= done_count_d;
      end
   end

endmodule
